// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pkg : shared constants and types for the LED matrix scanner      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int DEF_DWELL = 16;
  localparam int DEF_BLANK = 2;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } row_state_e;

  // [row][col]; arr[r] is the 8-bit column pattern of row r
  typedef logic [ROWS-1:0][COLS-1:0] led_array_t;

endpackage
`default_nettype wire

// File: rtl/led_matrix_scanner_row_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_timer : BLANK/DRIVE sequencing, dwell and row counters           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module row_timer
  import led_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int BLANK = DEF_BLANK
) (
  input  logic       clk,
  input  logic       reset,
  output row_state_e state,
  output logic [2:0] row,
  output logic [7:0] cnt,
  output logic       frame_end,
  output logic       frame_done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);

  row_state_e state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic       frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      row_q        <= 3'd0;
      cnt_q        <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The timer registers hold the cycle about to be shown; the output
  // registers in the top and frame_done_q sample it one edge later.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q + 8'd1;
    frame_end = (state_q == ST_DRIVE) && (row_q == 3'd7) && (cnt_q == DWELL_LAST);
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = 8'd0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = 8'd0;
          row_d   = row_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = 8'd0;
      end
    endcase
    frame_done_d = frame_end;
  end

  assign state      = state_q;
  assign row        = row_q;
  assign cnt        = cnt_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_scanner : double-buffered 8x8 red/green scanner with PWM  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int BLANK = DEF_BLANK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_load,
  input  led_array_t red_array,
  input  led_array_t green_array,
  input  logic [2:0] brightness,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] rowSink,
  output logic       frame_done
);

  localparam int STEP = DWELL / 8;

  row_state_e state;
  logic [2:0] row;
  logic [7:0] cnt;
  logic       frame_end;

  row_timer #(
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) u_row_timer (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .row       (row),
    .cnt       (cnt),
    .frame_end (frame_end),
    .frame_done(frame_done)
  );

  led_array_t shadow_red_q, shadow_red_d, shadow_green_q, shadow_green_d;
  led_array_t disp_red_q, disp_red_d, disp_green_q, disp_green_d;
  logic       pending_q, pending_d;
  logic [2:0] bright_q, bright_d;
  logic [7:0] red_q, red_d, green_q, green_d, row_sink_q, row_sink_d;
  logic [8:0] thresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_red_q   <= '0;
      shadow_green_q <= '0;
      disp_red_q     <= '0;
      disp_green_q   <= '0;
      pending_q      <= 1'b0;
      bright_q       <= 3'd7;
      red_q          <= 8'h00;
      green_q        <= 8'h00;
      row_sink_q     <= 8'hFF;
    end else begin
      shadow_red_q   <= shadow_red_d;
      shadow_green_q <= shadow_green_d;
      disp_red_q     <= disp_red_d;
      disp_green_q   <= disp_green_d;
      pending_q      <= pending_d;
      bright_q       <= bright_d;
      red_q          <= red_d;
      green_q        <= green_d;
      row_sink_q     <= row_sink_d;
    end
  end

  // A load landing on the boundary edge bypasses the shadow handoff so the
  // new picture is shown from the very next frame.
  always_comb begin
    shadow_red_d   = shadow_red_q;
    shadow_green_d = shadow_green_q;
    disp_red_d     = disp_red_q;
    disp_green_d   = disp_green_q;
    pending_d      = pending_q;
    bright_d       = bright_q;
    if (frame_end) begin
      bright_d = brightness;
      if (frame_load) begin
        shadow_red_d   = red_array;
        shadow_green_d = green_array;
        disp_red_d     = red_array;
        disp_green_d   = green_array;
        pending_d      = 1'b0;
      end else if (pending_q) begin
        disp_red_d   = shadow_red_q;
        disp_green_d = shadow_green_q;
        pending_d    = 1'b0;
      end
    end else if (frame_load) begin
      shadow_red_d   = red_array;
      shadow_green_d = green_array;
      pending_d      = 1'b1;
    end
  end

  always_comb begin
    red_d      = 8'h00;
    green_d    = 8'h00;
    row_sink_d = 8'hFF;
    thresh     = ({6'd0, bright_q} + 9'd1) * 9'(STEP);
    if (state == ST_DRIVE) begin
      row_sink_d = ~(8'd1 << row);
      if ({1'b0, cnt} < thresh) begin
        red_d   = disp_red_q[row];
        green_d = disp_green_q[row];
      end
    end
  end

  assign red     = red_q;
  assign green   = green_q;
  assign rowSink = row_sink_q;

endmodule
`default_nettype wire
